// File: rtl/fila_circular.sv
// Circular-buffer FIFO with pointer/count bookkeeping, flush and sticky error flags.
// Define FILA_PEEK_EN to add the show-ahead peek_out port.
`timescale 1ns/1ps
module fila_circular #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AF_TH  = 6
) (
    input  logic                   clk_10KHz,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   enqueue_in,
    input  logic                   dequeue_in,
    input  logic                   clear_in,
    output logic [DATA_W-1:0]      data_out,
`ifdef FILA_PEEK_EN
    output logic [DATA_W-1:0]      peek_out,
`endif
    output logic                   valid_out,
    output logic [$clog2(DEPTH):0] len_out,
    output logic                   full_out,
    output logic                   empty_out,
    output logic                   almost_full_out,
    output logic                   overflow_out,
    output logic                   underflow_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_TH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              enq_ok;
    logic              deq_ok;

    // Occupancy flags come straight from the registered count, so they
    // track the post-edge state without an extra cycle of lag.
    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign enq_ok = enqueue_in && (!full || dequeue_in);
    assign deq_ok = dequeue_in && !empty;

    assign len_out         = count;
    assign full_out        = full;
    assign empty_out       = empty;
    assign almost_full_out = (count >= AF_CNT);

`ifdef FILA_PEEK_EN
    assign peek_out = empty ? '0 : mem[rd_ptr];
`endif

    // Storage holds no reset value; stale words are never exposed.
    always_ff @(posedge clk_10KHz) begin
        if (enq_ok && !clear_in) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            data_out      <= '0;
            valid_out     <= 1'b0;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
        end else if (clear_in) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            valid_out     <= 1'b0;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
        end else begin
            valid_out <= deq_ok;
            if (enq_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (deq_ok) begin
                rd_ptr   <= rd_ptr + AW'(1);
                data_out <= mem[rd_ptr];
            end
            if (enq_ok && !deq_ok) begin
                count <= count + CW'(1);
            end else if (deq_ok && !enq_ok) begin
                count <= count - CW'(1);
            end
            if (enqueue_in && !enq_ok) begin
                overflow_out <= 1'b1;
            end
            if (dequeue_in && !deq_ok) begin
                underflow_out <= 1'b1;
            end
        end
    end

endmodule
